id_ex_operand_ctrl: RTL
=======================

ID_EX_OPERAND_CTRL -- requirements
Module: id_ex_operand_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: id_valid in 1, id_ready out 1 (decode handshake); ex_valid out 1, ex_ready in 1 (execute handshake).
REQ-004 SHALL have: id_alu_src in 3 (000 null, 001 r1_r2, 010 r1_im, 011 r1_nu, 100 im_nu, 101 r2_r1; 110/111 treated as null).
REQ-005 SHALL have: id_rs_a, id_rs_b in 4 (source register indices); id_data_a, id_data_b, id_imm in 16.
REQ-006 SHALL have: id_wb_en in 1, id_wb_reg in 4, id_is_load in 1 (decode instruction writes id_wb_reg, via memory if load).
REQ-007 SHALL have: mem_wb_en in 1, mem_wb_reg in 4, mem_wb_data in 16; wb_wb_en in 1, wb_wb_reg in 4, wb_wb_data in 16 (forwarding sources).
REQ-008 SHALL have: flush in 1 (kill held instruction).
REQ-009 SHALL have outputs: ex_alu_src 3, ex_data_a 16, ex_data_b 16, ex_imm 16, ex_wb_en 1, ex_wb_reg 4, ex_is_load 1.

Function
REQ-010 SHALL be an ID/EX stage register with forwarding and load-use interlock; capture latency one cycle.
REQ-011 SHALL treat operand A as used for codes 001, 010, 011, 101; operand B used for 001, 101 only.
REQ-012 SHALL forward at capture: per operand, if mem_wb_en and mem_wb_reg equals index, take mem_wb_data; else if WB forwarding match, take wb_wb_data; else id_data; MEM has priority.
REQ-013 SHALL never forward an unused operand; index 0 forwards normally (no hardwired zero).
REQ-014 SHALL run FSM states EMPTY, FULL, LU_STALL; reset state EMPTY.
REQ-015 SHALL detect load-use: ex_valid and ex_is_load and ex_wb_en and ex_wb_reg matches a used source of the decode instruction.
REQ-016 SHALL, on load-use with ex_ready=1, drive id_ready=0, load a bubble (ex_valid=0, ex_alu_src=000, ex_wb_en=0) and enter LU_STALL.
REQ-017 SHALL in LU_STALL drive id_ready=1 and capture the decode instruction next edge (now forwarded from MEM), then go FULL, or EMPTY if id_valid=0.
REQ-018 SHALL assert id_ready = ex_ready or not ex_valid, except REQ-016.
REQ-019 SHALL hold all ex_* outputs unchanged while ex_valid=1 and ex_ready=0.
REQ-020 SHALL transfer on id_valid and id_ready; with id_valid=0 and ex_ready=1, load a bubble and go EMPTY.
REQ-021 SHALL on flush load a bubble next edge, go EMPTY, ignore id_valid that cycle, override ex_ready=0 and load-use.
REQ-022 SHALL keep ex_valid low in EMPTY and LU_STALL.

Reset
REQ-023 SHALL on rst=0 immediately set state EMPTY, ex_valid 0, ex_alu_src 000, ex_data_a/b 0x0000, ex_imm 0x0000, ex_wb_en 0, ex_wb_reg 0, ex_is_load 0.
REQ-024 SHALL drive id_ready=1 during reset; reset mid-stall discards the held instruction.

Configuration
REQ-025 SHALL use macro ZZ_FWD_WB_EN: defined, WB-stage forwarding per REQ-012.
REQ-026 SHALL without ZZ_FWD_WB_EN forward from MEM only; wb_* inputs ignored (register file must write-through).

Verification
REQ-027 Reset: rst=0 mid-transfer -> all ex_* zero, ex_valid 0, id_ready 1 immediately.
REQ-028 Forward: id_alu_src=001, rs_a=3, rs_b=3, mem_wb_reg=3 data 0x1234, wb_wb_reg=3 data 0x5678 -> ex_data_a=ex_data_b=0x1234.
REQ-029 Load-use: EX holds load to r5, decode 010 rs_a=5 -> one bubble, id_ready 0 one cycle, then ex_data_a=mem_wb_data, ex_imm=id_imm.
REQ-030 Unused operand: EX load to r5, decode 010 rs_b=5 -> no stall, ex_data_b=id_data_b.
REQ-031 Backpressure: ex_ready=0 three cycles with id_valid=1 -> ex_* stable, id_ready 0; release -> next instruction captured one edge later.
REQ-032 Flush with ex_ready=0 and id_valid=1 -> next edge ex_valid 0, ex_alu_src 000, state EMPTY.

Source files
------------

// File: rtl/id_ex_operand_ctrl.sv
// ID/EX stage register with MEM/WB operand forwarding and load-use interlock.
// Define ZZ_FWD_WB_EN to enable forwarding from the WB stage; otherwise MEM only.
module id_ex_operand_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    output logic        id_ready,
    output logic        ex_valid,
    input  logic        ex_ready,
    input  logic [2:0]  id_alu_src,
    input  logic [3:0]  id_rs_a,
    input  logic [3:0]  id_rs_b,
    input  logic [15:0] id_data_a,
    input  logic [15:0] id_data_b,
    input  logic [15:0] id_imm,
    input  logic        id_wb_en,
    input  logic [3:0]  id_wb_reg,
    input  logic        id_is_load,
    input  logic        mem_wb_en,
    input  logic [3:0]  mem_wb_reg,
    input  logic [15:0] mem_wb_data,
    input  logic        wb_wb_en,
    input  logic [3:0]  wb_wb_reg,
    input  logic [15:0] wb_wb_data,
    input  logic        flush,
    output logic [2:0]  ex_alu_src,
    output logic [15:0] ex_data_a,
    output logic [15:0] ex_data_b,
    output logic [15:0] ex_imm,
    output logic        ex_wb_en,
    output logic [3:0]  ex_wb_reg,
    output logic        ex_is_load
);

    typedef enum logic [1:0] {EMPTY, FULL, LU_STALL} state_e;
    typedef enum logic [1:0] {ACT_HOLD, ACT_CAPTURE, ACT_BUBBLE} action_e;

    state_e      state_q, state_d;
    action_e     action;

    logic [2:0]  alu_src_q, alu_src_d;
    logic [15:0] data_a_q, data_a_d;
    logic [15:0] data_b_q, data_b_d;
    logic [15:0] imm_q, imm_d;
    logic        wb_en_q, wb_en_d;
    logic [3:0]  wb_reg_q, wb_reg_d;
    logic        is_load_q, is_load_d;

    logic [2:0]  src_norm;
    logic        a_used, b_used;
    logic        load_use;

    function automatic logic [15:0] fwd_operand(
        input logic [3:0]  idx,
        input logic        used,
        input logic [15:0] rf_data,
        input logic        m_en,
        input logic [3:0]  m_reg,
        input logic [15:0] m_data,
        input logic        w_en,
        input logic [3:0]  w_reg,
        input logic [15:0] w_data
    );
        logic [15:0] r;
        r = rf_data;
        if (used) begin
            if (m_en && m_reg == idx) begin
                r = m_data;
            end
`ifdef ZZ_FWD_WB_EN
            else if (w_en && w_reg == idx) begin
                r = w_data;
            end
`endif
        end
        return r;
    endfunction

`ifndef ZZ_FWD_WB_EN
    // Register file writes through, so the WB stage never needs a bypass.
    logic wb_fwd_unused;
    assign wb_fwd_unused = ^{wb_wb_en, wb_wb_reg, wb_wb_data};
`endif

    always_comb begin
        src_norm = (id_alu_src > 3'd5) ? 3'd0 : id_alu_src;
        a_used   = (src_norm == 3'd1) || (src_norm == 3'd2) ||
                   (src_norm == 3'd3) || (src_norm == 3'd5);
        b_used   = (src_norm == 3'd1) || (src_norm == 3'd5);
        load_use = id_valid && ex_valid && is_load_q && wb_en_q &&
                   ((a_used && id_rs_a == wb_reg_q) ||
                    (b_used && id_rs_b == wb_reg_q));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush outranks backpressure; the interlock only matters once EX can drain.
    always_comb begin
        state_d = state_q;
        action  = ACT_HOLD;
        if (flush) begin
            state_d = EMPTY;
            action  = ACT_BUBBLE;
        end else if (ex_valid && !ex_ready) begin
            state_d = state_q;
            action  = ACT_HOLD;
        end else if (load_use) begin
            state_d = LU_STALL;
            action  = ACT_BUBBLE;
        end else if (id_valid) begin
            state_d = FULL;
            action  = ACT_CAPTURE;
        end else begin
            state_d = EMPTY;
            action  = ACT_BUBBLE;
        end
    end

    always_comb begin
        ex_valid = (state_q == FULL);
        id_ready = !load_use && (ex_ready || !ex_valid);
    end

    always_comb begin
        alu_src_d = alu_src_q;
        data_a_d  = data_a_q;
        data_b_d  = data_b_q;
        imm_d     = imm_q;
        wb_en_d   = wb_en_q;
        wb_reg_d  = wb_reg_q;
        is_load_d = is_load_q;
        case (action)
            ACT_CAPTURE: begin
                alu_src_d = src_norm;
                data_a_d  = fwd_operand(id_rs_a, a_used, id_data_a,
                                        mem_wb_en, mem_wb_reg, mem_wb_data,
                                        wb_wb_en, wb_wb_reg, wb_wb_data);
                data_b_d  = fwd_operand(id_rs_b, b_used, id_data_b,
                                        mem_wb_en, mem_wb_reg, mem_wb_data,
                                        wb_wb_en, wb_wb_reg, wb_wb_data);
                imm_d     = id_imm;
                wb_en_d   = id_wb_en;
                wb_reg_d  = id_wb_reg;
                is_load_d = id_is_load;
            end
            ACT_BUBBLE: begin
                alu_src_d = '0;
                data_a_d  = '0;
                data_b_d  = '0;
                imm_d     = '0;
                wb_en_d   = 1'b0;
                wb_reg_d  = '0;
                is_load_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_src_q <= '0;
            data_a_q  <= '0;
            data_b_q  <= '0;
            imm_q     <= '0;
            wb_en_q   <= 1'b0;
            wb_reg_q  <= '0;
            is_load_q <= 1'b0;
        end else begin
            alu_src_q <= alu_src_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            imm_q     <= imm_d;
            wb_en_q   <= wb_en_d;
            wb_reg_q  <= wb_reg_d;
            is_load_q <= is_load_d;
        end
    end

    assign ex_alu_src = alu_src_q;
    assign ex_data_a  = data_a_q;
    assign ex_data_b  = data_b_q;
    assign ex_imm     = imm_q;
    assign ex_wb_en   = wb_en_q;
    assign ex_wb_reg  = wb_reg_q;
    assign ex_is_load = is_load_q;

endmodule
